// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use, branch-in-ID, MDU structural stalls,
// taken-branch flush, MDU occupancy down-counter and a saturating stall counter.
module hazard_ctrl #(
    parameter int unsigned MDU_CYCLES = 32,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_branch,
    input  logic             id_mdu_start,
    input  logic             id_mfhilo,
    input  logic [4:0]       ex_back,
    input  logic             ex_RegWrite,
    input  logic             ex_MemRead,
    input  logic [4:0]       mem_back,
    input  logic             mem_MemRead,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             mdu_start,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned CW = 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          hit_ex;
    logic          hit_mem;
    logic          lu;
    logic          br;
    logic          md;
    logic          stall;

    // A source only matters if it is really read and is not $0.
    function automatic logic src_hit(input logic [4:0] r, input logic use_r,
                                     input logic [4:0] dst);
        return use_r && (r != 5'd0) && (r == dst);
    endfunction

    assign mdu_busy = (state == BUSY);
    assign mdu_done = (state == BUSY) && (cnt == CW'(0));

    // Hazard detection and pipeline control, zero latency from inputs and state.
    always_comb begin
        hit_ex      = src_hit(id_rs, id_use_rs, ex_back)  || src_hit(id_rt, id_use_rt, ex_back);
        hit_mem     = src_hit(id_rs, id_use_rs, mem_back) || src_hit(id_rt, id_use_rt, mem_back);
        lu          = hit_ex && ex_MemRead;
        br          = id_branch && ((hit_ex && ex_RegWrite) || (hit_mem && mem_MemRead));
        md          = mdu_busy && (id_mdu_start || id_mfhilo);
        stall       = (lu || br || md) && !ex_branch_taken;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        mdu_start   = 1'b0;
        if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            mdu_start   = id_mdu_start;
        end
    end

    // MDU occupancy: cnt counts down from MDU_CYCLES-1, done on cnt==0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdu_start) begin
                        state <= BUSY;
                        cnt   <= CW'(MDU_CYCLES - 1);
                    end
                end
                BUSY: begin
                    if (cnt == CW'(0)) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Saturating stall-cycle counter; flush cycles never count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random stimulus
// against a cycle-level reference model (remaining-busy-cycles and stall tally).
module tb_hazard_ctrl;

    localparam int unsigned MDU_CYCLES = 4;
    localparam int unsigned CNT_W      = 32;
    localparam int unsigned SMALL_W    = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [4:0]         id_rs, id_rt, ex_back, mem_back;
    logic               id_use_rs, id_use_rt, id_branch, id_mdu_start, id_mfhilo;
    logic               ex_RegWrite, ex_MemRead, mem_MemRead, ex_branch_taken;
    logic               pc_write, ifid_write, ifid_flush, idex_bubble;
    logic               mdu_start, mdu_busy, mdu_done;
    logic [CNT_W-1:0]   stall_cycles;
    logic               s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble;
    logic               s_mdu_start, s_mdu_busy, s_mdu_done;
    logic [SMALL_W-1:0] s_stall_cycles;

    int     errors = 0;
    int     checks = 0;
    int     m_rem;
    longint m_stalls;
    int     busy_seen, done_seen;
    longint base;

    always #5 clk = ~clk;

    hazard_ctrl #(.MDU_CYCLES(MDU_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
        .id_mdu_start(id_mdu_start), .id_mfhilo(id_mfhilo), .ex_back(ex_back),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .mem_back(mem_back),
        .mem_MemRead(mem_MemRead), .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .mdu_start(mdu_start), .mdu_busy(mdu_busy),
        .mdu_done(mdu_done), .stall_cycles(stall_cycles)
    );

    hazard_ctrl #(.MDU_CYCLES(MDU_CYCLES), .CNT_W(SMALL_W)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
        .id_mdu_start(id_mdu_start), .id_mfhilo(id_mfhilo), .ex_back(ex_back),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .mem_back(mem_back),
        .mem_MemRead(mem_MemRead), .ex_branch_taken(ex_branch_taken),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
        .idex_bubble(s_idex_bubble), .mdu_start(s_mdu_start), .mdu_busy(s_mdu_busy),
        .mdu_done(s_mdu_done), .stall_cycles(s_stall_cycles)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit reads(input logic [4:0] r, input logic u, input logic [4:0] d);
        return u && (r != 5'd0) && (r == d);
    endfunction

    function automatic longint sat(input longint n, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; ex_back = 0; mem_back = 0;
        id_use_rs = 0; id_use_rt = 0; id_branch = 0; id_mdu_start = 0; id_mfhilo = 0;
        ex_RegWrite = 0; ex_MemRead = 0; mem_MemRead = 0; ex_branch_taken = 0;
    endtask

    // One pipeline cycle: check at the falling edge, then advance the model.
    task automatic step(input string tag);
        bit ex_dep, mem_dep, lu, br, md, stall, taken, start;
        @(negedge clk);
        ex_dep  = reads(id_rs, id_use_rs, ex_back)  || reads(id_rt, id_use_rt, ex_back);
        mem_dep = reads(id_rs, id_use_rs, mem_back) || reads(id_rt, id_use_rt, mem_back);
        lu      = ex_dep && ex_MemRead;
        br      = id_branch && ((ex_dep && ex_RegWrite) || (mem_dep && mem_MemRead));
        md      = (m_rem > 0) && (id_mdu_start || id_mfhilo);
        taken   = ex_branch_taken;
        stall   = (lu || br || md) && !taken;
        start   = id_mdu_start && !stall && !taken;
        check({tag, ".pc_write"},    64'(pc_write),    64'(!stall));
        check({tag, ".ifid_write"},  64'(ifid_write),  64'(!stall));
        check({tag, ".ifid_flush"},  64'(ifid_flush),  64'(taken));
        check({tag, ".idex_bubble"}, 64'(idex_bubble), 64'(stall || taken));
        check({tag, ".mdu_start"},   64'(mdu_start),   64'(start));
        check({tag, ".mdu_busy"},    64'(mdu_busy),    64'(m_rem > 0));
        check({tag, ".mdu_done"},    64'(mdu_done),    64'(m_rem == 1));
        check({tag, ".stall_cycles"},   64'(stall_cycles),   64'(sat(m_stalls, CNT_W)));
        check({tag, ".s_stall_cycles"}, 64'(s_stall_cycles), 64'(sat(m_stalls, SMALL_W)));
        check({tag, ".s_idex_bubble"},  64'(s_idex_bubble),  64'(stall || taken));
        busy_seen += int'(mdu_busy);
        done_seen += int'(mdu_done);
        if (start)          m_rem = MDU_CYCLES;
        else if (m_rem > 0) m_rem--;
        if (stall)          m_stalls++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_rem = 0;
        m_stalls = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        m_rem = 0;
        m_stalls = 0;
        busy_seen = 0;
        done_seen = 0;
        #1;
        check("rst.pc_write",     64'(pc_write),     64'(1));
        check("rst.ifid_write",   64'(ifid_write),   64'(1));
        check("rst.ifid_flush",   64'(ifid_flush),   64'(0));
        check("rst.idex_bubble",  64'(idex_bubble),  64'(0));
        check("rst.mdu_busy",     64'(mdu_busy),     64'(0));
        check("rst.mdu_done",     64'(mdu_done),     64'(0));
        check("rst.mdu_start",    64'(mdu_start),    64'(0));
        check("rst.stall_cycles", 64'(stall_cycles), 64'(0));
        do_reset();

        // Load-use on rs
        ex_back = 5; ex_MemRead = 1; ex_RegWrite = 1; id_rs = 5; id_use_rs = 1;
        step("lu");
        check("lu.count", 64'(stall_cycles), 64'(1));
        // $0 and unused operand never stall
        id_rs = 0;
        step("lu_r0");
        id_rs = 5; id_use_rs = 0;
        step("lu_unused");
        check("lu_none.count", 64'(stall_cycles), 64'(1));

        // Branch depending on a load: EX then MEM
        clear_inputs();
        base = longint'(stall_cycles);
        id_branch = 1; id_rt = 9; id_use_rt = 1;
        ex_back = 9; ex_MemRead = 1; ex_RegWrite = 1;
        step("br_ld_ex");
        ex_back = 0; ex_MemRead = 0; ex_RegWrite = 0; mem_back = 9; mem_MemRead = 1;
        step("br_ld_mem");
        mem_back = 0; mem_MemRead = 0;
        step("br_go");
        check("br_ld.stalls", 64'(longint'(stall_cycles) - base), 64'(2));

        // MDU start then mfhi held in ID
        clear_inputs();
        base = longint'(stall_cycles);
        busy_seen = 0; done_seen = 0;
        id_mdu_start = 1;
        step("mdu_start");
        id_mdu_start = 0; id_mfhilo = 1;
        repeat (6) step("mdu_mfhi");
        check("mdu.busy_cycles", 64'(busy_seen), 64'(MDU_CYCLES));
        check("mdu.done_pulses", 64'(done_seen), 64'(1));
        check("mdu.mfhi_stalls", 64'(longint'(stall_cycles) - base), 64'(MDU_CYCLES));

        // Flush beats load-use
        clear_inputs();
        base = longint'(stall_cycles);
        ex_back = 5; ex_MemRead = 1; ex_RegWrite = 1; id_rs = 5; id_use_rs = 1;
        ex_branch_taken = 1; id_mdu_start = 1;
        step("flush");
        check("flush.count", 64'(stall_cycles), 64'(base));
        check("flush.no_mdu", 64'(mdu_busy), 64'(0));

        // Asynchronous reset in the second busy cycle
        clear_inputs();
        id_mdu_start = 1;
        step("rst_mdu_start");
        id_mdu_start = 0;
        step("rst_mdu_busy1");
        #2 rst_n = 1'b0;
        #1;
        check("async.mdu_busy",     64'(mdu_busy),     64'(0));
        check("async.mdu_done",     64'(mdu_done),     64'(0));
        check("async.stall_cycles", 64'(stall_cycles), 64'(0));
        m_rem = 0;
        m_stalls = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Saturation of the narrow counter (all-ones is 7)
        ex_back = 7; ex_MemRead = 1; id_rt = 7; id_use_rt = 1;
        repeat (10) step("sat");
        check("sat.s_hold", 64'(s_stall_cycles), 64'(7));

        // Random traffic over a small register set to provoke overlaps
        for (int i = 0; i < 500; i++) begin
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_back         = 5'($urandom_range(0, 3));
            mem_back        = 5'($urandom_range(0, 3));
            id_use_rs       = 1'($urandom_range(0, 1));
            id_use_rt       = 1'($urandom_range(0, 1));
            id_branch       = ($urandom_range(0, 3) == 0);
            id_mdu_start    = ($urandom_range(0, 5) == 0);
            id_mfhilo       = ($urandom_range(0, 5) == 0);
            ex_RegWrite     = 1'($urandom_range(0, 1));
            ex_MemRead      = ($urandom_range(0, 3) == 0);
            mem_MemRead     = ($urandom_range(0, 3) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
